lsu_mem_ctrl: RTL

Load/store controller between the core's execute stage and the word-addressed `memory` block. It accepts one load or store per handshake and checks alignment and address range before any access. It issues exactly one single-cycle memory operation, so the memory's read/write conflict condition can never be hit. It returns load data sign- or zero-extended, together with a 2-bit error code that uses the memory's state encoding.

---
 rtl/lsu_mem_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: checks alignment and range, issues one single-cycle
// memory access, and returns an extended load result with a 2-bit error code.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH        = 12,
  parameter int MEMORY_SIZE_WORDS = 1024,
  parameter int ERR_CNT_WIDTH     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [31:0]              req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [1:0]               req_size,
  input  logic                     req_signed,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic [1:0]               rsp_err,
  output logic                     mem_r_en,
  output logic                     mem_w_en,
  output logic [ADDR_WIDTH-1:0]    mem_r_addr,
  output logic [ADDR_WIDTH-1:0]    mem_w_addr,
  output logic [31:0]              mem_w_data,
  output logic [1:0]               mem_r_bmul,
  output logic [1:0]               mem_w_bmul,
  input  logic [31:0]              mem_r_data,
  input  logic [1:0]               mem_state,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t state, state_next;

  logic       cap_we;
  logic [1:0] cap_size;
  logic       cap_signed;
  logic       misaligned;
  logic       out_of_range;
  logic [31:0] load_ext;

  logic                  req_ready_next;
  logic                  rsp_valid_next;
  logic [31:0]           rsp_rdata_next;
  logic [1:0]            rsp_err_next;
  logic                  mem_r_en_next;
  logic                  mem_w_en_next;
  logic [ADDR_WIDTH-1:0] mem_r_addr_next;
  logic [ADDR_WIDTH-1:0] mem_w_addr_next;
  logic [31:0]           mem_w_data_next;
  logic [1:0]            mem_r_bmul_next;
  logic [1:0]            mem_w_bmul_next;

  always_comb begin
    misaligned   = (req_size == 2'd3) ||
                   (req_size == 2'd1 && req_addr[0]) ||
                   (req_size == 2'd2 && req_addr[1:0] != 2'b00);
    out_of_range = ((req_addr >> ADDR_WIDTH) != 32'd0) ||
                   (32'(req_addr[ADDR_WIDTH-1:2]) >= 32'(MEMORY_SIZE_WORDS));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = (misaligned || out_of_range) ? RESP : ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Only the fields needed after the access leaves ISSUE are kept here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_we     <= 1'b0;
      cap_size   <= 2'd0;
      cap_signed <= 1'b0;
    end else if (state == IDLE && req_valid) begin
      cap_we     <= req_we;
      cap_size   <= req_size;
      cap_signed <= req_signed;
    end
  end

  always_comb begin
    case (cap_size)
      2'd0:    load_ext = {{24{cap_signed & mem_r_data[7]}}, mem_r_data[7:0]};
      2'd1:    load_ext = {{16{cap_signed & mem_r_data[15]}}, mem_r_data[15:0]};
      default: load_ext = mem_r_data;
    endcase
  end

  // Output next-values; memory controls are loaded on acceptance so the
  // enable is high exactly during the ISSUE cycle.
  always_comb begin
    req_ready_next  = (state_next == IDLE);
    rsp_valid_next  = (state_next == RESP);
    rsp_rdata_next  = rsp_rdata;
    rsp_err_next    = rsp_err;
    mem_r_en_next   = 1'b0;
    mem_w_en_next   = 1'b0;
    mem_r_addr_next = mem_r_addr;
    mem_w_addr_next = mem_w_addr;
    mem_w_data_next = mem_w_data;
    mem_r_bmul_next = mem_r_bmul;
    mem_w_bmul_next = mem_w_bmul;
    case (state)
      IDLE: begin
        if (req_valid) begin
          rsp_rdata_next = 32'd0;
          if (misaligned) begin
            rsp_err_next = 2'b11;
          end else if (out_of_range) begin
            rsp_err_next = 2'b10;
          end else begin
            rsp_err_next = 2'b00;
            if (req_we) begin
              mem_w_en_next   = 1'b1;
              mem_w_addr_next = req_addr[ADDR_WIDTH-1:0];
              mem_w_data_next = req_wdata;
              mem_w_bmul_next = req_size;
            end else begin
              mem_r_en_next   = 1'b1;
              mem_r_addr_next = req_addr[ADDR_WIDTH-1:0];
              mem_r_bmul_next = req_size;
            end
          end
        end
      end
      WAIT: begin
        rsp_err_next   = mem_state;
        rsp_rdata_next = (!cap_we && mem_state == 2'b00) ? load_ext : 32'd0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'd0;
      rsp_err    <= 2'b00;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      mem_r_addr <= '0;
      mem_w_addr <= '0;
      mem_w_data <= 32'd0;
      mem_r_bmul <= 2'd0;
      mem_w_bmul <= 2'd0;
    end else begin
      req_ready  <= req_ready_next;
      rsp_valid  <= rsp_valid_next;
      rsp_rdata  <= rsp_rdata_next;
      rsp_err    <= rsp_err_next;
      mem_r_en   <= mem_r_en_next;
      mem_w_en   <= mem_w_en_next;
      mem_r_addr <= mem_r_addr_next;
      mem_w_addr <= mem_w_addr_next;
      mem_w_data <= mem_w_data_next;
      mem_r_bmul <= mem_r_bmul_next;
      mem_w_bmul <= mem_w_bmul_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (rsp_valid && rsp_ready && rsp_err != 2'b00 && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule
